// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory bus controller.
//   load_mode_e / store_mode_e : RV32I funct3 codes for loads and stores
//   dmem_state_e               : controller FSM states
//   store_lane_t               : byte enables plus lane-placed store data
package dmem_pkg;

   localparam int unsigned TAG_W  = 16;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned LAT_W  = 3;

   typedef enum logic [2:0] {
      LM_LB  = 3'd0,
      LM_LH  = 3'd1,
      LM_LW  = 3'd2,
      LM_LBU = 3'd4,
      LM_LHU = 3'd5
   } load_mode_e;

   typedef enum logic [2:0] {
      SM_SB = 3'd0,
      SM_SH = 3'd1,
      SM_SW = 3'd2
   } store_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } dmem_state_e;

   typedef struct packed {
      logic [3:0]        byteen;
      logic [WORD_W-1:0] data;
   } store_lane_t;

   // Sub-word stores replicate the LSB-aligned data so every lane carries it.
   function automatic store_lane_t store_lanes(input logic [2:0]        mode,
                                               input logic [1:0]        offset,
                                               input logic [WORD_W-1:0] data);
      store_lane_t s;
      s.byteen = 4'b0000;
      s.data   = '0;
      case (mode)
         SM_SB: begin
            s.byteen = 4'b0001 << offset;
            s.data   = {4{data[7:0]}};
         end
         SM_SH: begin
            s.byteen = offset[1] ? 4'b1100 : 4'b0011;
            s.data   = {2{data[15:0]}};
         end
         SM_SW: begin
            s.byteen = 4'b1111;
            s.data   = data;
         end
         default: ;
      endcase
      return s;
   endfunction

   // Legal mode code with natural alignment; unknown codes are illegal.
   function automatic logic access_legal(input logic       write_enable,
                                         input logic [2:0] write_mode,
                                         input logic [2:0] read_mode,
                                         input logic [1:0] offset);
      logic ok;
      ok = 1'b0;
      if (write_enable) begin
         case (write_mode)
            SM_SB:   ok = 1'b1;
            SM_SH:   ok = ~offset[0];
            SM_SW:   ok = (offset == 2'b00);
            default: ok = 1'b0;
         endcase
      end else begin
         case (read_mode)
            LM_LB, LM_LBU: ok = 1'b1;
            LM_LH, LM_LHU: ok = ~offset[0];
            LM_LW:         ok = (offset == 2'b00);
            default:       ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Load result formatter: extracts and extends a byte/halfword/word.
//   load_word : raw 32-bit word from the region
//   offset    : byte offset address[1:0]
//   mode      : load funct3
//   result    : formatted load value (0 for unknown modes)
module load_formatter
   import dmem_pkg::*;
(
   input  logic [WORD_W-1:0] load_word,
   input  logic [1:0]        offset,
   input  logic [2:0]        mode,
   output logic [WORD_W-1:0] result
);

   logic [WORD_W-1:0] shifted;
   logic [7:0]        byte_val;
   logic [15:0]       half_val;

   // Bring the addressed byte/halfword down to bit 0.
   always_comb begin
      shifted  = load_word >> {offset, 3'b000};
      byte_val = shifted[7:0];
      half_val = shifted[15:0];
   end

   always_comb begin
      result = '0;
      case (mode)
         LM_LB:   result = {{24{byte_val[7]}}, byte_val};
         LM_LH:   result = {{16{half_val[15]}}, half_val};
         LM_LW:   result = load_word;
         LM_LBU:  result = {24'd0, byte_val};
         LM_LHU:  result = {16'd0, half_val};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/dmem_controller.sv
// Data-memory bus controller between the core dmem port and N regions.
//   clk, reset_n             : clock, synchronous active-low reset
//   dmem_*                   : core request (address, enable, write enable,
//                              modes, store data) and response (read data,
//                              wait, fault pulse, last fault address)
//   reg_enable               : one-hot region enable, valid in request cycle
//   reg_write_enable/address/byteen/write_data : shared region bus
//   reg_read_data            : concatenated region read words
module dmem_controller
   import dmem_pkg::*;
#(
   parameter int unsigned                     NUM_REGIONS = 3,
   parameter logic [TAG_W*NUM_REGIONS-1:0]    REGION_TAG  = {16'h8000, 16'h7000, 16'h0000},
   parameter logic [LAT_W*NUM_REGIONS-1:0]    REGION_LAT  = {3'd1, 3'd1, 3'd1},
   parameter int unsigned                     REGION_AW   = 14
)(
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [31:0]                   dmem_address,
   input  logic                          dmem_enable,
   input  logic                          dmem_write_enable,
   input  logic [2:0]                    dmem_write_mode,
   input  logic [2:0]                    dmem_read_mode,
   input  logic [31:0]                   dmem_write_data,
   output logic [31:0]                   dmem_read_data,
   output logic                          dmem_wait,
   output logic                          dmem_fault,
   output logic [31:0]                   dmem_fault_address,
   output logic [NUM_REGIONS-1:0]        reg_enable,
   output logic                          reg_write_enable,
   output logic [REGION_AW-1:0]          reg_address,
   output logic [3:0]                    reg_byteen,
   output logic [31:0]                   reg_write_data,
   input  logic [WORD_W*NUM_REGIONS-1:0] reg_read_data
);

   localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

   dmem_state_e       state_q, state_d;
   logic [LAT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  cap_region_q, cap_region_d;
   logic [1:0]        cap_offset_q, cap_offset_d;
   logic [2:0]        cap_mode_q, cap_mode_d;
   logic              valid_q, valid_d;
   logic              fault_d;
   logic [31:0]       fault_addr_d;

   logic              hit;
   logic [IDX_W-1:0]  hit_idx;
   logic [LAT_W-1:0]  hit_lat;
   logic              legal;
   logic              accept;
   logic              go;
   store_lane_t       lanes;
   logic [WORD_W-1:0] sel_word;
   logic [WORD_W-1:0] fmt_data;

   // Lowest-index region whose tag matches wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      hit_lat = '0;
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
         if (!hit && (dmem_address[31:16] == REGION_TAG[TAG_W*i +: TAG_W])) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
            hit_lat = REGION_LAT[LAT_W*i +: LAT_W];
         end
      end
   end

   assign legal  = hit && access_legal(dmem_write_enable, dmem_write_mode,
                                       dmem_read_mode, dmem_address[1:0]);
   assign accept = dmem_enable && (state_q == IDLE);
   assign go     = accept && legal;
   assign lanes  = store_lanes(dmem_write_mode, dmem_address[1:0], dmem_write_data);

   // Region bus is driven only in the cycle a legal request is accepted.
   always_comb begin
      reg_enable       = '0;
      reg_write_enable = 1'b0;
      reg_address      = '0;
      reg_byteen       = 4'b0000;
      reg_write_data   = '0;
      if (go) begin
         reg_enable       = NUM_REGIONS'(1) << hit_idx;
         reg_write_enable = dmem_write_enable;
         reg_address      = dmem_address[REGION_AW+1:2];
         if (dmem_write_enable) begin
            reg_byteen     = lanes.byteen;
            reg_write_data = lanes.data;
         end
      end
   end

   // Next-state: accept in IDLE, count down read latency in BUSY.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cap_region_d = cap_region_q;
      cap_offset_d = cap_offset_q;
      cap_mode_d   = cap_mode_q;
      valid_d      = valid_q;
      fault_d      = 1'b0;
      fault_addr_d = dmem_fault_address;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!legal) begin
                  fault_d      = 1'b1;
                  fault_addr_d = dmem_address;
                  valid_d      = 1'b0;
               end else if (!dmem_write_enable) begin
                  cap_region_d = hit_idx;
                  cap_offset_d = dmem_address[1:0];
                  cap_mode_d   = dmem_read_mode;
                  valid_d      = 1'b1;
                  if (hit_lat > 3'd1) begin
                     state_d = BUSY;
                     cnt_d   = hit_lat - 3'd1;
                  end
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q            <= IDLE;
         cnt_q              <= '0;
         cap_region_q       <= '0;
         cap_offset_q       <= '0;
         cap_mode_q         <= '0;
         valid_q            <= 1'b0;
         dmem_fault         <= 1'b0;
         dmem_fault_address <= '0;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         cap_region_q       <= cap_region_d;
         cap_offset_q       <= cap_offset_d;
         cap_mode_q         <= cap_mode_d;
         valid_q            <= valid_d;
         dmem_fault         <= fault_d;
         dmem_fault_address <= fault_addr_d;
      end
   end

   assign dmem_wait = (state_q == BUSY);
   assign sel_word  = reg_read_data[WORD_W*cap_region_q +: WORD_W];

   load_formatter u_fmt (
      .load_word (sel_word),
      .offset    (cap_offset_q),
      .mode      (cap_mode_q),
      .result    (fmt_data)
   );

   // Region output is only meaningful once the latency has elapsed.
   assign dmem_read_data = (valid_q && (state_q == IDLE)) ? fmt_data : '0;

endmodule

// File: tb/tb_dmem_controller.sv
// Randomised self-checking bench for dmem_controller with six regions
// (one shadowed by a duplicate tag) and latencies 1, 3, 5.
module tb_dmem_controller;

   localparam int NR = 6;

   logic            clk;
   logic            reset_n;
   logic [31:0]     dmem_address;
   logic            dmem_enable;
   logic            dmem_write_enable;
   logic [2:0]      dmem_write_mode;
   logic [2:0]      dmem_read_mode;
   logic [31:0]     dmem_write_data;
   logic [31:0]     dmem_read_data;
   logic            dmem_wait;
   logic            dmem_fault;
   logic [31:0]     dmem_fault_address;
   logic [NR-1:0]   reg_enable;
   logic            reg_write_enable;
   logic [13:0]     reg_address;
   logic [3:0]      reg_byteen;
   logic [31:0]     reg_write_data;
   logic [32*NR-1:0] reg_read_data;

   // Region map: 0 ROM, 1 MMIO, 2 RAM, 3 slow, 4 slower, 5 shadow of RAM.
   int          tb_lat [NR] = '{1, 1, 1, 3, 5, 2};
   logic [15:0] tb_tag [NR] = '{16'h0000, 16'h7000, 16'h8000, 16'h3000, 16'h5000, 16'h8000};

   dmem_controller #(
      .NUM_REGIONS (NR),
      .REGION_TAG  ({16'h8000, 16'h5000, 16'h3000, 16'h8000, 16'h7000, 16'h0000}),
      .REGION_LAT  ({3'd2, 3'd5, 3'd3, 3'd1, 3'd1, 3'd1}),
      .REGION_AW   (14)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .dmem_address       (dmem_address),
      .dmem_enable        (dmem_enable),
      .dmem_write_enable  (dmem_write_enable),
      .dmem_write_mode    (dmem_write_mode),
      .dmem_read_mode     (dmem_read_mode),
      .dmem_write_data    (dmem_write_data),
      .dmem_read_data     (dmem_read_data),
      .dmem_wait          (dmem_wait),
      .dmem_fault         (dmem_fault),
      .dmem_fault_address (dmem_fault_address),
      .reg_enable         (reg_enable),
      .reg_write_enable   (reg_write_enable),
      .reg_address        (reg_address),
      .reg_byteen         (reg_byteen),
      .reg_write_data     (reg_write_data),
      .reg_read_data      (reg_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] init_word(input int r, input int w);
      return (32'(r) * 32'h0100_0193 + 32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
   endfunction

   // ---------------- region models (bus slaves) ----------------
   logic [31:0] rmem [NR][256];
   logic [31:0] rout [NR];
   int          rcnt [NR];
   logic [7:0]  raddr [NR];
   bit          mem_ready = 1'b0;

   always_comb begin
      reg_read_data = '0;
      for (int i = 0; i < NR; i++) reg_read_data[32*i +: 32] = rout[i];
   end

   // Read data appears LAT edges after the enable and is held; poisoned before.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < NR; i++) begin
            for (int w = 0; w < 256; w++) rmem[i][w] = init_word(i, w);
            rout[i] <= 32'h0;
            rcnt[i] = 0;
            raddr[i] = 8'h0;
         end
         mem_ready = 1'b1;
      end
      for (int i = 0; i < NR; i++) begin
         if (rcnt[i] > 0) begin
            rcnt[i] = rcnt[i] - 1;
            if (rcnt[i] == 0) rout[i] <= rmem[i][raddr[i]];
         end
         if (reg_enable[i]) begin
            if (reg_write_enable) begin
               for (int b = 0; b < 4; b++)
                  if (reg_byteen[b]) rmem[i][reg_address[7:0]][8*b +: 8] = reg_write_data[8*b +: 8];
            end else begin
               raddr[i] = reg_address[7:0];
               if (tb_lat[i] == 1) rout[i] <= rmem[i][reg_address[7:0]];
               else begin
                  rcnt[i] = tb_lat[i] - 1;
                  rout[i] <= rmem[i][reg_address[7:0]] ^ 32'hBAD0_0BAD;
               end
            end
         end
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [NR][256];
   logic [31:0] last_rd;
   logic [31:0] last_fault_addr;
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int find_region(input logic [31:0] a);
      for (int i = 0; i < NR; i++) if (a[31:16] == tb_tag[i]) return i;
      return -1;
   endfunction

   function automatic bit mode_ok(input logic we, input int mode, input int off);
      if (we) begin
         if (mode == 0) return 1'b1;
         if (mode == 1) return (off % 2) == 0;
         if (mode == 2) return off == 0;
         return 1'b0;
      end
      if (mode == 0 || mode == 4) return 1'b1;
      if (mode == 1 || mode == 5) return (off % 2) == 0;
      if (mode == 2) return off == 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input int r, input int widx, input int off, input int mode);
      logic [31:0] w, b, h;
      w = ref_mem[r][widx];
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (8 * off)) & 32'hFFFF;
      case (mode)
         0:       return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
         4:       return b;
         1:       return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         5:       return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] size_mask(input int mode);
      if (mode == 0) return 32'hFF;
      if (mode == 1) return 32'hFFFF;
      return 32'hFFFF_FFFF;
   endfunction

   // One request: cycle T, wait cycles with ignored garbage, then one idle cycle.
   task automatic access(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd_got,
                         output logic [3:0] be_got, output logic [31:0] wd_got);
      int r, off, widx, lat;
      bit legal;
      logic [31:0] lmask;
      r     = find_region(addr);
      off   = int'(addr[1:0]);
      widx  = int'(addr[9:2]);
      legal = (r >= 0) && mode_ok(we, int'(mode), off);
      lat   = 1;
      @(posedge clk); #1;
      dmem_enable       = 1'b1;
      dmem_write_enable = we;
      dmem_address      = addr;
      dmem_write_data   = wd;
      dmem_write_mode   = we ? mode : 3'($urandom);
      dmem_read_mode    = we ? 3'($urandom) : mode;
      @(negedge clk);
      be_got = reg_byteen;
      wd_got = reg_write_data;
      check("wait_at_T", 32'(dmem_wait), 32'd0);
      check("fault_clear_at_T", 32'(dmem_fault), 32'd0);
      check("rdata_hold_at_T", dmem_read_data, last_rd);
      if (!legal) begin
         check("reg_en_illegal", 32'(reg_enable), 32'd0);
         last_rd         = 32'h0;
         last_fault_addr = addr;
      end else begin
         check("reg_en", 32'(reg_enable), 32'd1 << r);
         check("reg_we", 32'(reg_write_enable), 32'(we));
         check("reg_addr", 32'(reg_address), 32'(addr[15:2]));
         if (we) begin
            lmask = size_mask(int'(mode)) << (8 * off);
            check("byteen", 32'(reg_byteen),
                  (mode == 3'd0) ? (32'd1 << off) : (mode == 3'd1) ? (32'd3 << off) : 32'hF);
            check("wdata_lanes", reg_write_data & lmask, (wd << (8 * off)) & lmask);
            ref_mem[r][widx] = (ref_mem[r][widx] & ~lmask) | ((wd << (8 * off)) & lmask);
         end else begin
            last_rd = ref_load(r, widx, off, int'(mode));
            lat     = tb_lat[r];
         end
      end
      for (int c = 1; c < lat; c++) begin
         @(posedge clk); #1;
         dmem_enable       = 1'($urandom);
         dmem_write_enable = 1'($urandom);
         dmem_address      = {16'h8000, 6'd0, 10'($urandom)};
         dmem_write_data   = $urandom;
         @(negedge clk);
         check("wait_high", 32'(dmem_wait), 32'd1);
         check("ignored_in_wait", 32'(reg_enable), 32'd0);
      end
      @(posedge clk); #1;
      dmem_enable       = 1'b0;
      dmem_write_enable = 1'b0;
      @(negedge clk);
      check("wait_done", 32'(dmem_wait), 32'd0);
      check("fault_pulse", 32'(dmem_fault), 32'(!legal));
      check("fault_addr", dmem_fault_address, last_fault_addr);
      check("rdata", dmem_read_data, last_rd);
      check("idle_bus", {27'd0, reg_write_enable, reg_byteen} | 32'(reg_enable) | reg_write_data, 32'd0);
      rd_got = dmem_read_data;
   endtask

   logic [31:0] rd, wdg, ea, eb;
   logic [3:0]  be;
   int          load_modes [8] = '{0, 1, 2, 4, 5, 0, 2, 4};
   logic [15:0] rnd_tags [5] = '{16'h0000, 16'h7000, 16'h8000, 16'h3000, 16'h5000};

   initial begin
      for (int i = 0; i < NR; i++)
         for (int w = 0; w < 256; w++) ref_mem[i][w] = init_word(i, w);
      last_rd = 32'h0;
      last_fault_addr = 32'h0;
      reset_n = 1'b0;
      dmem_enable = 1'b0;
      dmem_write_enable = 1'b0;
      dmem_address = 32'h0;
      dmem_write_mode = 3'd0;
      dmem_read_mode = 3'd0;
      dmem_write_data = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_wait", 32'(dmem_wait), 32'd0);
      check("rst_fault", 32'(dmem_fault), 32'd0);
      check("rst_fault_addr", dmem_fault_address, 32'd0);
      check("rst_rdata", dmem_read_data, 32'd0);
      check("rst_reg_en", 32'(reg_enable), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Store word then signed/unsigned byte loads from the RAM.
      access(1'b1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, rd, be, wdg);
      check("sw_byteen", 32'(be), 32'hF);
      access(1'b0, 3'd0, 32'h8000_0007, 32'h0, rd, be, wdg);
      check("lb_value", rd, 32'hFFFF_FFDE);
      access(1'b0, 3'd4, 32'h8000_0007, 32'h0, rd, be, wdg);
      check("lbu_value", rd, 32'h0000_00DE);

      // Upper halfword store and halfword loads.
      access(1'b1, 3'd1, 32'h8000_0002, 32'h0000_A5B6, rd, be, wdg);
      check("sh_byteen", 32'(be), 32'hC);
      check("sh_upper_lane", 32'(wdg[31:16]), 32'h0000_A5B6);
      access(1'b0, 3'd1, 32'h8000_0002, 32'h0, rd, be, wdg);
      check("lh_value", rd, 32'hFFFF_A5B6);
      access(1'b0, 3'd5, 32'h8000_0002, 32'h0, rd, be, wdg);
      check("lhu_value", rd, 32'h0000_A5B6);

      // Latency-3 word load with garbage presented during the wait.
      access(1'b0, 3'd2, 32'h3000_0010, 32'h0, rd, be, wdg);
      check("lat3_word", rd, init_word(3, 4));

      // Misaligned and unmapped word loads fault.
      access(1'b0, 3'd2, 32'h8000_0002, 32'h0, rd, be, wdg);
      access(1'b0, 3'd2, 32'h1234_0000, 32'h0, rd, be, wdg);
      check("unmapped_fault_addr", dmem_fault_address, 32'h1234_0000);

      // Reset during a latency-5 load aborts it.
      @(posedge clk); #1;
      dmem_enable = 1'b1; dmem_write_enable = 1'b0;
      dmem_read_mode = 3'd2; dmem_address = 32'h5000_0020;
      @(negedge clk);
      check("lat5_reg_en", 32'(reg_enable), 32'd1 << 4);
      @(posedge clk); #1;
      reset_n = 1'b0; dmem_enable = 1'b0;
      @(negedge clk);
      check("lat5_wait_before_rst", 32'(dmem_wait), 32'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("abort_wait", 32'(dmem_wait), 32'd0);
      check("abort_fault", 32'(dmem_fault), 32'd0);
      check("abort_rdata", dmem_read_data, 32'd0);
      check("abort_fault_addr", dmem_fault_address, 32'd0);
      last_rd = 32'h0;
      last_fault_addr = 32'h0;
      access(1'b0, 3'd2, 32'h7000_0008, 32'h0, rd, be, wdg);
      check("post_rst_load", rd, init_word(1, 2));

      // Back-to-back latency-1 loads from ROM then MMIO.
      ea = ref_load(0, 16, 0, 2);
      eb = ref_load(1, 32, 0, 2);
      @(posedge clk); #1;
      dmem_enable = 1'b1; dmem_write_enable = 1'b0;
      dmem_read_mode = 3'd2; dmem_address = 32'h0000_0040;
      @(negedge clk);
      check("b2b_en_rom", 32'(reg_enable), 32'd1);
      @(posedge clk); #1;
      dmem_address = 32'h7000_0080;
      @(negedge clk);
      check("b2b_rom_data", dmem_read_data, ea);
      check("b2b_en_mmio", 32'(reg_enable), 32'd2);
      check("b2b_wait", 32'(dmem_wait), 32'd0);
      @(posedge clk); #1;
      dmem_enable = 1'b0;
      @(negedge clk);
      check("b2b_mmio_data", dmem_read_data, eb);
      last_rd = eb;

      // Random traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         logic        we;
         logic [2:0]  md;
         logic [15:0] tg;
         we = ($urandom_range(0, 2) == 0);
         tg = ($urandom_range(0, 9) == 0) ? 16'h1234 : rnd_tags[$urandom_range(0, 4)];
         if (we) md = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         else    md = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
                                                  : 3'(load_modes[$urandom_range(0, 7)]);
         access(we, md, {tg, 6'd0, 10'($urandom)}, $urandom, rd, be, wdg);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
